// File: rtl/bus_fifo_in.sv
// ----------------------------------------------------------------------------
// bus_fifo_in
//
// Per-driver input FIFO placed directly upstream of the bus generator/arbiter.
// The agent writes packets with push/D_in. The bus driver sees the oldest
// entry on D_pop, first-word-fall-through, qualified by pndng. It consumes
// that entry with pop.
//
// Parameters
//   width  packet width in bits (matches the bus driver pckg_sz)
//   depth  number of entries; any value >= 2, power of two not required
//
// Ports
//   clk       in   single clock, all state updates on the rising edge
//   reset     in   synchronous, active-high; has priority over push/pop
//   push      in   agent write strobe
//   D_in      in   agent write data, sampled when push = 1
//   pop       in   bus driver read strobe; consumes the current head
//   D_pop     out  head entry; all zeros when empty
//   pndng     out  FIFO holds at least one entry
//   full      out  FIFO holds depth entries
//   count     out  occupancy, 0..depth
//   overflow  out  sticky: a push arrived while full without a same-cycle
//                  pop. Only reset clears it.
//
// Configuration macro
//   FIFO_OVERWRITE_EN  when defined, a push into a full FIFO without a pop
//                      overwrites the oldest entry. When undefined (the
//                      default), that push is dropped. overflow is set in
//                      both cases.
//
// Every output comes from registered state. No input reaches an output
// through combinational logic.
// ----------------------------------------------------------------------------
module bus_fifo_in #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [width-1:0]         D_in,
  input  logic                     pop,
  output logic [width-1:0]         D_pop,
  output logic                     pndng,
  output logic                     full,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth) + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LAST_PTR  = ptr_t'(depth - 1);
  localparam cnt_t DEPTH_CNT = cnt_t'(depth);

  // Depth need not be a power of two. The wrap from the last slot back to
  // slot 0 is therefore an explicit compare, not natural binary rollover.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [width-1:0] mem_q [depth];
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  cnt_t             count_q,  count_d;
  logic             overflow_q, overflow_d;

  // --------------------------------------------------------------------------
  // Per-edge decode
  // --------------------------------------------------------------------------
  logic is_empty;
  logic is_full;
  logic do_push;     // accepted write that grows or replaces via a real pop
  logic do_pop;      // accepted read
  logic ovf_event;   // push while full with no pop alongside it
  logic overwrite;   // ovf_event that replaces the oldest entry
  logic wr_en;       // any write into the storage array this edge

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_CNT);

  // A pop on an empty FIFO is ignored. A push and a pop together on an empty
  // FIFO therefore behave as a plain push, with no bypass to D_pop.
  assign do_pop    = pop & ~is_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted when a pop comes with it.
  assign do_push   = push & (~is_full | pop);
  assign ovf_event = push & is_full & ~pop;

`ifdef FIFO_OVERWRITE_EN
  // Here wr_ptr equals rd_ptr. Writing there and advancing both pointers
  // drops the oldest entry and appends the new one. count stays at depth.
  assign overwrite = ovf_event;
`else
  assign overwrite = 1'b0;
`endif

  assign wr_en = do_push | overwrite;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: combinational blocks assign a default to every output first, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | ovf_event;

    if (wr_en) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop || overwrite) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // An overwrite is neither do_push nor do_pop, so it leaves count as is.
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge value, and evaluation order cannot matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array
  // --------------------------------------------------------------------------
  // NOTE: the data array is deliberately not reset. Stale contents are never
  // observable: D_pop is forced to zero while count is zero, and every slot
  // is written before it becomes the head again. Skipping the reset lets the
  // array map onto plain storage.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= D_in;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (registered state only)
  // --------------------------------------------------------------------------
  assign D_pop    = is_empty ? '0 : mem_q[rd_ptr_q];
  assign pndng    = ~is_empty;
  assign full     = is_full;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bus_fifo_in.sv
// ----------------------------------------------------------------------------
// tb_bus_fifo_in
//
// Self-checking bench for bus_fifo_in. Instance u_a uses depth 8, and
// instance u_b uses depth 5 for the non-power-of-two wrap case. Each
// instance has a reference model built on a queue. On every falling edge,
// the model's view of the outputs is compared with the DUT. Directed
// sequences also pin hand-computed literal values. Compile with
// +define+FIFO_OVERWRITE_EN to check the overwrite build.
// ----------------------------------------------------------------------------
module tb_bus_fifo_in;

  localparam int W = 16;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  // depth-8 instance signals
  logic          a_reset, a_push, a_pop;
  logic [W-1:0]  a_din, a_dpop;
  logic          a_pndng, a_full, a_ovf;
  logic [3:0]    a_count;

  // depth-5 instance signals
  logic          b_reset, b_push, b_pop;
  logic [W-1:0]  b_din, b_dpop;
  logic          b_pndng, b_full, b_ovf;
  logic [3:0]    b_count;

  bus_fifo_in #(.width(W), .depth(8)) u_a (
    .clk(clk), .reset(a_reset), .push(a_push), .D_in(a_din), .pop(a_pop),
    .D_pop(a_dpop), .pndng(a_pndng), .full(a_full), .count(a_count),
    .overflow(a_ovf)
  );

  bus_fifo_in #(.width(W), .depth(5)) u_b (
    .clk(clk), .reset(b_reset), .push(b_push), .D_in(b_din), .pop(b_pop),
    .D_pop(b_dpop), .pndng(b_pndng), .full(b_full), .count(b_count),
    .overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference models: occupancy as a queue, applying the FIFO rules directly
  // --------------------------------------------------------------------------
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  bit ovf_a = 0, ovf_b = 0;
  bit va = 0, vb = 0;

  always @(posedge clk) begin
    if (a_reset) begin
      qa.delete(); ovf_a = 0; va = 1;
    end else if (va) begin
      if (a_push && qa.size() == 8 && !a_pop) begin
        ovf_a = 1;
`ifdef FIFO_OVERWRITE_EN
        void'(qa.pop_front());
        qa.push_back(a_din);
`endif
      end else begin
        if (a_pop && qa.size() != 0) void'(qa.pop_front());
        if (a_push) qa.push_back(a_din);
      end
    end
  end

  always @(posedge clk) begin
    if (b_reset) begin
      qb.delete(); ovf_b = 0; vb = 1;
    end else if (vb) begin
      if (b_push && qb.size() == 5 && !b_pop) begin
        ovf_b = 1;
`ifdef FIFO_OVERWRITE_EN
        void'(qb.pop_front());
        qb.push_back(b_din);
`endif
      end else begin
        if (b_pop && qb.size() != 0) void'(qb.pop_front());
        if (b_push) qb.push_back(b_din);
      end
    end
  end

  // Every-cycle comparison against the models
  always @(negedge clk) begin
    if (va) begin
      check("a.count", 32'(a_count), 32'(qa.size()));
      check("a.pndng", 32'(a_pndng), 32'(qa.size() != 0));
      check("a.full",  32'(a_full),  32'(qa.size() == 8));
      check("a.D_pop", 32'(a_dpop),  (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
      check("a.overflow", 32'(a_ovf), 32'(ovf_a));
    end
    if (vb) begin
      check("b.count", 32'(b_count), 32'(qb.size()));
      check("b.pndng", 32'(b_pndng), 32'(qb.size() != 0));
      check("b.full",  32'(b_full),  32'(qb.size() == 5));
      check("b.D_pop", 32'(b_dpop),  (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
      check("b.overflow", 32'(b_ovf), 32'(ovf_b));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus: each call drives one rising edge and returns at the next fall
  // --------------------------------------------------------------------------
  task automatic cyc_a(input logic r, input logic ps, input logic [W-1:0] d,
                       input logic pp);
    a_reset = r; a_push = ps; a_din = d; a_pop = pp;
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic r, input logic ps, input logic [W-1:0] d,
                       input logic pp);
    b_reset = r; b_push = ps; b_din = d; b_pop = pp;
    @(negedge clk);
  endtask

  task automatic fill_a(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) cyc_a(1'b0, 1'b1, base + W'(i), 1'b0);
  endtask

  initial begin
    logic [W-1:0] exp_v;
    a_reset = 1'b1; a_push = 1'b0; a_din = '0; a_pop = 1'b0;
    b_reset = 1'b1; b_push = 1'b0; b_din = '0; b_pop = 1'b0;

    // Reset then idle
    cyc_a(1'b1, 1'b0, '0, 1'b0);
    cyc_a(1'b1, 1'b0, '0, 1'b0);
    check("rst.count", 32'(a_count), 32'd0);
    check("rst.pndng", 32'(a_pndng), 32'd0);
    check("rst.full",  32'(a_full),  32'd0);
    check("rst.D_pop", 32'(a_dpop),  32'd0);
    check("rst.overflow", 32'(a_ovf), 32'd0);
    cyc_a(1'b0, 1'b1, 16'hAAAA, 1'b0);
    check("first.pndng", 32'(a_pndng), 32'd1);
    check("first.D_pop", 32'(a_dpop),  32'hAAAA);
    check("first.count", 32'(a_count), 32'd1);

    // Fill and drain
    cyc_a(1'b1, 1'b0, '0, 1'b0);
    fill_a(8, 16'h0001);
    check("fill.full",  32'(a_full),  32'd1);
    check("fill.count", 32'(a_count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check("drain.D_pop", 32'(a_dpop), 32'(i));
      cyc_a(1'b0, 1'b0, '0, 1'b1);
    end
    check("drain.pndng", 32'(a_pndng), 32'd0);
    check("drain.D_pop_zero", 32'(a_dpop), 32'd0);
    check("drain.overflow", 32'(a_ovf), 32'd0);

    // Overflow: push while full with no pop
    cyc_a(1'b1, 1'b0, '0, 1'b0);
    fill_a(8, 16'h0001);
    cyc_a(1'b0, 1'b1, 16'h00FF, 1'b0);
    check("ovf.overflow", 32'(a_ovf), 32'd1);
    check("ovf.count", 32'(a_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_OVERWRITE_EN
      exp_v = (i < 7) ? W'(i + 2) : 16'h00FF;
`else
      exp_v = W'(i + 1);
`endif
      check("ovf.drain", 32'(a_dpop), 32'(exp_v));
      cyc_a(1'b0, 1'b0, '0, 1'b1);
    end
    check("ovf.sticky", 32'(a_ovf), 32'd1);

    // Push and pop together while full: no overflow
    cyc_a(1'b1, 1'b0, '0, 1'b0);
    fill_a(8, 16'h0001);
    cyc_a(1'b0, 1'b1, 16'h0099, 1'b1);
    check("fullpp.count", 32'(a_count), 32'd8);
    check("fullpp.overflow", 32'(a_ovf), 32'd0);
    check("fullpp.D_pop", 32'(a_dpop), 32'h0002);

    // Pop on empty; push and pop together on empty
    cyc_a(1'b1, 1'b0, '0, 1'b0);
    cyc_a(1'b0, 1'b0, '0, 1'b1);
    check("popempty.count", 32'(a_count), 32'd0);
    check("popempty.D_pop", 32'(a_dpop), 32'd0);
    check("popempty.overflow", 32'(a_ovf), 32'd0);
    cyc_a(1'b0, 1'b1, 16'h0055, 1'b1);
    check("ppempty.count", 32'(a_count), 32'd1);
    check("ppempty.D_pop", 32'(a_dpop), 32'h0055);

    // Reset in the middle of a drain, with push and pop also active
    cyc_a(1'b1, 1'b0, '0, 1'b0);
    fill_a(6, 16'h0010);
    cyc_a(1'b0, 1'b0, '0, 1'b1);
    cyc_a(1'b0, 1'b0, '0, 1'b1);
    check("middrain.count", 32'(a_count), 32'd4);
    cyc_a(1'b1, 1'b1, 16'h0077, 1'b1);
    check("midrst.count", 32'(a_count), 32'd0);
    check("midrst.pndng", 32'(a_pndng), 32'd0);
    cyc_a(1'b0, 1'b1, 16'h1234, 1'b0);
    check("postrst.D_pop", 32'(a_dpop), 32'h1234);
    cyc_a(1'b0, 1'b0, '0, 1'b0);

    // Wrap-around on depth 5: preload 2, then 12 push+pop cycles
    cyc_b(1'b1, 1'b0, '0, 1'b0);
    cyc_b(1'b0, 1'b1, 16'h0200, 1'b0);
    cyc_b(1'b0, 1'b1, 16'h0201, 1'b0);
    for (int i = 0; i < 12; i++) begin
      exp_v = (i == 0) ? 16'h0200 : (i == 1) ? 16'h0201 : W'(16'h0100 + i - 2);
      check("wrap.head", 32'(b_dpop), 32'(exp_v));
      cyc_b(1'b0, 1'b1, W'(16'h0100 + i), 1'b1);
      check("wrap.count", 32'(b_count), 32'd2);
    end
    check("wrap.final_head", 32'(b_dpop), 32'h010A);
    cyc_b(1'b0, 1'b0, '0, 1'b0);
    cyc_b(1'b0, 1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
